// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART byte transmitter between NREQ producers.
// Optionally prefixes each data byte with a channel-ID header byte.
//
// state   | meaning
// IDLE    | waiting for a requester; req_ready asserted for the RR winner
// H_ACK   | header start issued, waiting for tx_busy to rise
// H_DONE  | header frame in progress, waiting for tx_busy to fall
// D_START | issue start pulse for the latched data byte
// D_ACK   | data start issued, waiting for tx_busy to rise
// D_DONE  | data frame in progress, waiting for tx_busy to fall
module uart_tx_sched #(
    parameter int          NREQ     = 4,
    parameter int          IDW      = 2,
    parameter bit          HDR_EN   = 1'b1,
    parameter logic [7:0]  HDR_BASE = 8'hA0,
    parameter int          ACK_TO   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic [IDW-1:0]    grant_id,
    output logic              busy,
    output logic              err
);

    localparam int             CW      = $clog2(ACK_TO + 1);
    localparam logic [CW-1:0]  TO_LAST = CW'(ACK_TO - 1);

    typedef enum logic [2:0] {IDLE, H_ACK, H_DONE, D_START, D_ACK, D_DONE} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic [7:0]      byte_q, byte_d;
    logic [7:0]      txd_q, txd_d;
    logic            start_q, start_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            win_found;
    logic [IDW-1:0]  win_idx;
    logic [7:0]      win_byte;
    logic            accept;

    // Search upward from ptr+1 with wrap; first valid channel wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!win_found &&
                ((req_valid & (NREQ'(1) << ((int'(ptr_q) + k) % NREQ))) != '0)) begin
                win_found = 1'b1;
                win_idx   = IDW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    assign win_byte  = 8'(req_data >> (8 * int'(win_idx)));
    assign accept    = (state_q == IDLE) && en && win_found;
    assign req_ready = accept ? (NREQ'(1) << win_idx) : '0;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        byte_d  = byte_q;
        txd_d   = txd_q;
        start_d = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        byte_d  = win_byte;
                        grant_d = win_idx;
                        start_d = 1'b1;
                        cnt_d   = '0;
                        if (HDR_EN) begin
                            txd_d   = HDR_BASE | 8'(win_idx);
                            state_d = H_ACK;
                        end else begin
                            txd_d   = win_byte;
                            state_d = D_ACK;
                        end
                    end
                end
                H_ACK, D_ACK: begin
                    // A busy flag already high on entry counts as the acknowledge.
                    if (tx_busy) begin
                        state_d = (state_q == H_ACK) ? H_DONE : D_DONE;
                    end else if (cnt_q == TO_LAST) begin
                        err_d   = 1'b1;
                        ptr_d   = grant_q;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                H_DONE: begin
                    if (!tx_busy) state_d = D_START;
                end
                D_START: begin
                    txd_d   = byte_q;
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = D_ACK;
                end
                D_DONE: begin
                    if (!tx_busy) begin
                        ptr_d   = grant_q;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= IDW'(NREQ - 1);
            grant_q <= '0;
            byte_q  <= '0;
            txd_q   <= '0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            byte_q  <= byte_d;
            txd_q   <= txd_d;
            start_q <= start_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign tx_data  = txd_q;
    assign tx_start = start_q;
    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);
    assign err      = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: one header-enabled and one header-less instance
// sharing a behavioural transmitter model.
module tb_uart_tx_sched;

    localparam int         ACK_TO   = 16;
    localparam logic [7:0] HDR_BASE = 8'hA0;
    localparam int         LAT      = 2;
    localparam int         LEN      = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic [3:0]  valid_a = '0, valid_b = '0;
    logic [31:0] data_a = '0, data_b = '0;
    logic [3:0]  ready_a, ready_b;
    logic [7:0]  txd_a, txd_b;
    logic        txs_a, txs_b, busy_a, busy_b, err_a, err_b;
    logic [1:0]  gid_a, gid_b;
    logic        tx_busy = 1'b0;

    int n_cmp = 0, n_fail = 0, cyc = 0;
    int start_cnt_a = 0, start_cnt_b = 0, err_cnt_a = 0;
    int start_cyc_a = 0, err_cyc_a = 0;
    int nak_cnt = 0, ph = 0;
    bit err_busy_a = 1'b0, lat_a = 1'b0, lat_b = 1'b0;
    int         acc_q_a[$], acc_q_b[$];
    logic [7:0] exp_a[$], exp_b[$];

    uart_tx_sched #(.NREQ(4), .IDW(2), .HDR_EN(1'b1), .HDR_BASE(HDR_BASE), .ACK_TO(ACK_TO)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .req_valid(valid_a), .req_data(data_a),
        .req_ready(ready_a), .tx_data(txd_a), .tx_start(txs_a), .tx_busy(tx_busy),
        .grant_id(gid_a), .busy(busy_a), .err(err_a));

    uart_tx_sched #(.NREQ(4), .IDW(2), .HDR_EN(1'b0), .HDR_BASE(HDR_BASE), .ACK_TO(ACK_TO)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .req_valid(valid_b), .req_data(data_b),
        .req_ready(ready_b), .tx_data(txd_b), .tx_start(txs_b), .tx_busy(tx_busy),
        .grant_id(gid_b), .busy(busy_b), .err(err_b));

    always #5 clk = ~clk;

    // Transmitter model: busy rises LAT cycles after a start, stays high LEN cycles.
    always @(negedge clk) begin
        if ((txs_a || txs_b) && nak_cnt > 0) nak_cnt = nak_cnt - 1;
        else if (txs_a || txs_b) ph = 1;
        else if (ph > 0) ph = (ph >= LAT + LEN - 1) ? 0 : ph + 1;
        tx_busy = (ph >= LAT);
    end

    // Scoreboard: accepts push expected bytes, start pulses pop and compare.
    always @(negedge clk) begin
        logic [3:0] acc;
        logic [7:0] e;
        cyc++;
        if (!rst_n) begin
            exp_a.delete(); exp_b.delete();
            lat_a = 1'b0; lat_b = 1'b0;
        end else begin
            acc = valid_a & ready_a;
            if (lat_a) begin
                n_cmp++;
                if (txs_a !== 1'b1) begin n_fail++; $display("FAIL start_latency_a: tx_start=%b required 1", txs_a); end
            end
            if (txs_a) begin
                if (start_cnt_a == 0) start_cyc_a = cyc;
                start_cnt_a++;
                n_cmp++;
                if (exp_a.size() == 0) begin
                    n_fail++; $display("FAIL sb_a: unexpected tx_start with tx_data=%h", txd_a);
                end else begin
                    e = exp_a.pop_front();
                    if (txd_a !== e) begin n_fail++; $display("FAIL sb_a: tx_data=%h required %h", txd_a, e); end
                end
            end
            if (err_a) begin
                err_cnt_a++; err_cyc_a = cyc; err_busy_a = busy_a;
                exp_a.delete();
            end
            lat_a = (acc != 0);
            if (acc != 0) begin
                n_cmp++;
                if ($countones(acc) != 1) begin n_fail++; $display("FAIL onehot_a: accepted=%b required one bit", acc); end
                for (int i = 0; i < 4; i++) if (acc[i]) begin
                    acc_q_a.push_back(i);
                    exp_a.push_back(HDR_BASE | 8'(i));
                    exp_a.push_back(data_a[8*i +: 8]);
                end
            end

            acc = valid_b & ready_b;
            if (lat_b) begin
                n_cmp++;
                if (txs_b !== 1'b1) begin n_fail++; $display("FAIL start_latency_b: tx_start=%b required 1", txs_b); end
            end
            if (txs_b) begin
                start_cnt_b++;
                n_cmp++;
                if (exp_b.size() == 0) begin
                    n_fail++; $display("FAIL sb_b: unexpected tx_start with tx_data=%h", txd_b);
                end else begin
                    e = exp_b.pop_front();
                    if (txd_b !== e) begin n_fail++; $display("FAIL sb_b: tx_data=%h required %h", txd_b, e); end
                end
            end
            lat_b = (acc != 0);
            for (int i = 0; i < 4; i++) if (acc[i]) begin
                acc_q_b.push_back(i);
                exp_b.push_back(data_b[8*i +: 8]);
            end
        end
    end

    task automatic step;
        @(posedge clk); #1;
    endtask

    // Runs until n accepts on dut_a; optionally drops each channel's valid once accepted.
    task automatic run_a(input int n, input bit drop_each, input int lim, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < lim; k++) begin
            step;
            if (drop_each && acc_q_a.size() > 0) valid_a[acc_q_a[acc_q_a.size()-1]] = 1'b0;
            if (acc_q_a.size() >= n) begin valid_a = '0; ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle(input int lim, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < lim; k++) begin
            step;
            if (!busy_a && !busy_b && !tx_busy && exp_a.size() == 0 && exp_b.size() == 0) begin
                ok = 1'b1; break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b1;
        step; step;
        n_cmp++; if (txd_a !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: %h required 00", txd_a); end
        n_cmp++; if (txs_a !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: %b required 0", txs_a); end
        n_cmp++; if (gid_a !== 2'd0) begin n_fail++; $display("FAIL reset_grant: %0d required 0", gid_a); end
        n_cmp++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin n_fail++; $display("FAIL reset_busy: %b%b required 00", busy_a, busy_b); end
        n_cmp++; if (err_a !== 1'b0 || err_b !== 1'b0) begin n_fail++; $display("FAIL reset_err: %b%b required 00", err_a, err_b); end
        n_cmp++; if (ready_a !== 4'b0) begin n_fail++; $display("FAIL reset_ready: %b required 0000", ready_a); end
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        int rdy = 0;
        bit ok = 1'b0;
        start_cnt_a = 0; acc_q_a.delete();
        data_a[23:16] = 8'h5A; valid_a = 4'b0100;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (ready_a[2]) rdy++;
            step;
            if (acc_q_a.size() > 0) valid_a = '0;
            if (start_cnt_a == 2 && !busy_a) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL single_done: starts=%0d busy=%b required 2 and 0", start_cnt_a, busy_a); end
        n_cmp++; if (rdy != 1) begin n_fail++; $display("FAIL single_ready_cycles: %0d required 1", rdy); end
        n_cmp++; if (acc_q_a.size() != 1 || acc_q_a[0] != 2) begin n_fail++; $display("FAIL single_channel: n=%0d required one accept of ch2", acc_q_a.size()); end
        n_cmp++; if (gid_a !== 2'd2) begin n_fail++; $display("FAIL single_grant: %0d required 2", gid_a); end
        wait_idle(300, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL single_idle: timed out waiting for idle"); end
    endtask

    task automatic test_round_robin;
        int order[5] = '{0, 1, 2, 3, 0};
        bit ok;
        step; rst_n = 1'b0; step; rst_n = 1'b1;
        acc_q_a.delete();
        data_a = {8'h13, 8'h12, 8'h11, 8'h10}; valid_a = 4'hF;
        run_a(5, 1'b0, 3000, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rr_accepts: %0d required 5", acc_q_a.size()); end
        for (int i = 0; i < 5 && i < acc_q_a.size(); i++) begin
            n_cmp++;
            if (acc_q_a[i] != order[i]) begin n_fail++; $display("FAIL rr_order[%0d]: ch%0d required ch%0d", i, acc_q_a[i], order[i]); end
        end
        wait_idle(400, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rr_idle: timed out waiting for idle"); end
        n_cmp++; if (gid_a !== 2'd0) begin n_fail++; $display("FAIL rr_grant: %0d required 0", gid_a); end
    endtask

    task automatic test_hdr_off;
        bit ok = 1'b0;
        start_cnt_b = 0; acc_q_b.delete();
        data_b[15:8] = 8'hC3; valid_b = 4'b0010;
        for (int k = 0; k < 400; k++) begin
            step;
            if (acc_q_b.size() > 0) valid_b = '0;
            if (acc_q_b.size() > 0 && !busy_b && !tx_busy && exp_b.size() == 0) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL nohdr_done: timed out"); end
        n_cmp++; if (start_cnt_b != 1) begin n_fail++; $display("FAIL nohdr_starts: %0d required 1", start_cnt_b); end
        n_cmp++; if (gid_b !== 2'd1) begin n_fail++; $display("FAIL nohdr_grant: %0d required 1", gid_b); end
        n_cmp++; if (txd_b !== 8'hC3) begin n_fail++; $display("FAIL nohdr_tx_data: %h required C3", txd_b); end
    endtask

    task automatic test_timeout;
        bit ok;
        start_cnt_a = 0; err_cnt_a = 0; acc_q_a.delete();
        data_a[15:8] = 8'h66; data_a[23:16] = 8'h67; valid_a = 4'b0110;
        nak_cnt = 1;
        run_a(2, 1'b1, 600, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL to_accepts: %0d required 2", acc_q_a.size()); end
        wait_idle(400, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL to_idle: timed out waiting for idle"); end
        n_cmp++; if (err_cnt_a != 1) begin n_fail++; $display("FAIL to_err_cycles: %0d required 1", err_cnt_a); end
        n_cmp++; if (err_cyc_a - start_cyc_a != ACK_TO) begin n_fail++; $display("FAIL to_err_delay: %0d required %0d", err_cyc_a - start_cyc_a, ACK_TO); end
        n_cmp++; if (err_busy_a !== 1'b0) begin n_fail++; $display("FAIL to_idle_at_err: busy=%b required 0", err_busy_a); end
        n_cmp++; if (acc_q_a.size() != 2 || acc_q_a[0] != 1 || acc_q_a[1] != 2) begin n_fail++; $display("FAIL to_order: n=%0d required ch1 then ch2", acc_q_a.size()); end
        n_cmp++; if (start_cnt_a != 3) begin n_fail++; $display("FAIL to_starts: %0d required 3", start_cnt_a); end
    endtask

    task automatic test_abort;
        int dd = 0;
        bit ok;
        start_cnt_a = 0; acc_q_a.delete();
        data_a[31:24] = 8'h77; valid_a = 4'b1000;
        run_a(1, 1'b1, 300, ok);
        for (int k = 0; k < 400 && dd < 3; k++) begin
            step;
            if (start_cnt_a == 2 && tx_busy) dd++;
        end
        n_cmp++; if (dd < 3) begin n_fail++; $display("FAIL abort_reach_ddone: starts=%0d required 2", start_cnt_a); end
        en = 1'b0;
        step;
        n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL abort_busy: %b required 0", busy_a); end
        n_cmp++; if (txs_a !== 1'b0 || err_a !== 1'b0) begin n_fail++; $display("FAIL abort_pulses: start=%b err=%b required 0 0", txs_a, err_a); end
        n_cmp++; if (gid_a !== 2'd3 || txd_a !== 8'h77) begin n_fail++; $display("FAIL abort_retain: grant=%0d tx_data=%h required 3 77", gid_a, txd_a); end
        data_a[31:24] = 8'h78; data_a[7:0] = 8'h79; valid_a = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++; if (ready_a !== 4'b0) begin n_fail++; $display("FAIL abort_ready: %b required 0000", ready_a); end
        end
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin step; if (!tx_busy) begin ok = 1'b1; break; end end
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL abort_tx_drain: tx_busy stuck high"); end
        en = 1'b1; acc_q_a.delete();
        run_a(2, 1'b1, 1000, ok);
        n_cmp++; if (!ok || acc_q_a[0] != 3 || acc_q_a[1] != 0) begin n_fail++; $display("FAIL abort_resume_order: n=%0d required ch3 then ch0", acc_q_a.size()); end
        wait_idle(400, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL abort_idle: timed out waiting for idle"); end
    endtask

    task automatic test_reset_mid;
        int dd = 0;
        bit ok;
        start_cnt_a = 0; acc_q_a.delete();
        data_a[23:16] = 8'h22; valid_a = 4'b0100;
        run_a(1, 1'b1, 300, ok);
        for (int k = 0; k < 400 && dd < 3; k++) begin
            step;
            if (start_cnt_a == 1 && tx_busy) dd++;
        end
        n_cmp++; if (dd < 3 || acc_q_a.size() != 1 || acc_q_a[0] != 2) begin n_fail++; $display("FAIL rstmid_reach_hdone: starts=%0d required ch2 header", start_cnt_a); end
        data_a = {8'h23, 8'h22, 8'h21, 8'h20}; valid_a = 4'hF;
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        n_cmp++; if (txd_a !== 8'h00 || txs_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_tx: data=%h start=%b required 00 0", txd_a, txs_a); end
        n_cmp++; if (gid_a !== 2'd0 || busy_a !== 1'b0 || err_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_state: grant=%0d busy=%b err=%b required 0 0 0", gid_a, busy_a, err_a); end
        acc_q_a.delete();
        run_a(1, 1'b1, 300, ok);
        n_cmp++; if (!ok || acc_q_a[0] != 0) begin n_fail++; $display("FAIL rstmid_first: n=%0d required ch0 first", acc_q_a.size()); end
        wait_idle(400, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rstmid_idle: timed out waiting for idle"); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_hdr_off;
        test_timeout;
        test_abort;
        test_reset_mid;
        n_cmp++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            n_fail++; $display("FAIL sb_leftover: a=%0d b=%0d required 0 0", exp_a.size(), exp_b.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one UART byte transmitter between NREQ byte producers.
- Accepts one byte at a time over a valid/ready handshake and optionally sends a channel-ID header byte before it.
- Drives the transmitter with a one-cycle start pulse, then tracks the transmitter's busy flag until the frame completes.
- Sits between the application byte sources and the shared UART TX + baud generator.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of grant_id; must satisfy 2^IDW >= NREQ
- HDR_EN, 1, 1 = send header byte (HDR_BASE | channel index) before each data byte; 0 = data byte only
- HDR_BASE, 8'hA0, header base value; low IDW bits must be 0
- ACK_TO, 16, max cycles to wait for tx_busy to rise after tx_start

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  global enable; low = synchronous abort/hold idle
- req_valid  in  NREQ  per-channel byte available
- req_data  in  8*NREQ  channel i byte on bits [8i+7:8i]
- req_ready  out  NREQ  combinational; byte i accepted on an edge where valid[i] & ready[i]
- tx_data  out  8  byte presented to transmitter; stable from tx_start until busy falls
- tx_start  out  1  one-cycle start pulse to transmitter
- tx_busy  in  1  transmitter frame in progress
- grant_id  out  IDW  channel currently being served
- busy  out  1  scheduler not in IDLE
- err  out  1  one-cycle pulse on ACK timeout

Behaviour:
- Reset values: tx_data=0, tx_start=0, grant_id=0, busy=0, err=0, state=IDLE. RR pointer=NREQ-1, so channel 0 has first priority.
- States: IDLE, H_ACK, H_DONE, D_START, D_ACK, D_DONE.
- Round-robin winner: first i with req_valid[i], searching upward from pointer+1 with wrap.
- req_ready[winner]=1 only when state==IDLE and en=1; all other bits are 0.
- IDLE, on accept edge: latch byte into an internal register and set grant_id=winner.
  - HDR_EN=1: set tx_data=HDR_BASE|winner, tx_start=1, go to H_ACK.
  - HDR_EN=0: set tx_data=byte, tx_start=1, go to D_ACK.
- Latency: tx_start is high exactly in the cycle after the accept edge.
- tx_start is forced to 0 on the edge after it was set; it is never high for two consecutive cycles.
- H_ACK / D_ACK: wait for tx_busy=1, then go to H_DONE / D_DONE. The cycle counter starts at 0 on entry.
  - If the counter reaches ACK_TO-1 without tx_busy: err=1 for one cycle, go to IDLE, byte is dropped, pointer is set to grant_id.
- H_DONE: when tx_busy=0, go to D_START.
- D_START: set tx_data=latched byte, tx_start=1, go to D_ACK. There is one idle cycle between the busy fall and the next tx_start.
- D_DONE: when tx_busy=0, pointer=grant_id, go to IDLE. A new accept is possible on the next edge.
- busy=1 in every state except IDLE. grant_id holds its value until the next accept.
- Simultaneous requests: exactly one is accepted per transaction. A channel asserting valid continuously is served at most once per NREQ transactions while others request.
- tx_busy already high on entry to an ACK state counts as acknowledged; there is no edge detection.
- en=0 (any state): next edge → IDLE, tx_start=0, err=0, req_ready all 0. Pointer, tx_data and grant_id are retained. An in-flight byte is abandoned and the transmitter is not told.
- rst_n=0 mid-transaction: all registers go to their reset values on that edge. rst_n has priority over en.
- req_data is sampled only on the accept edge. Later changes are ignored.

Test Plan:
- Single request: HDR_EN=1, valid[2]=1, data[2]=8'h5A; model TX raises busy 2 cycles after start and drops it 100 cycles later → tx_data 8'hA2 then 8'h5A, two tx_start pulses, req_ready[2] high 1 cycle, grant_id=2, busy falls after second frame.
- Round-robin: all four valid continuously with distinct bytes 8'h10..8'h13 → data bytes sent in channel order 0,1,2,3,0. No channel is served twice before the others.
- HDR_EN=0: valid[1]=1, data 8'hC3 → exactly one tx_start with tx_data=8'hC3, one cycle after the accept edge.
- ACK timeout: the model never raises tx_busy → err pulses 1 cycle at ACK_TO cycles after entering H_ACK; state returns to IDLE; the next transaction serves the next channel after the dropped one.
- Abort: en dropped during D_DONE → IDLE on next edge, req_ready=0 while en=0. After en=1, the pending channel is accepted and the pointer is unchanged.
- Reset mid-frame: rst_n=0 for 1 cycle during H_DONE → all outputs 0, pointer=NREQ-1; with all channels valid, channel 0 is served first.
